// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by the arbiter and its logic unit
package alu_pkg;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NOTA} op_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
endpackage

// File: rtl/logic_unit.sv
// logic_unit: bitwise AND/OR/XOR/NOT-A, all-zero output while disabled
module logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = !en ? '0 :
        op == OP_AND ? a & b :
        op == OP_OR  ? a | b :
        op == OP_XOR ? a ^ b : ~a;
  end
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin two-requester front end for a registered logic unit
module logic_unit_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             busy
);
  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d, lu_y;
  logic             g0, g1, en;
  assign g0 = req0_valid && (!req1_valid || last_q);
  assign g1 = req1_valid && !g0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    if (state_q == S_IDLE && (g0 || g1)) begin
      state_d = S_EXEC;
      last_d  = g1;
      id_d    = g1;
      op_d    = g1 ? req1_op : req0_op;
      a_d     = g1 ? req1_a : req0_a;
      b_d     = g1 ? req1_b : req0_b;
    end
    if (state_q == S_EXEC) begin
      state_d = S_RESP;
      data_d  = lu_y;
    end
    if (state_q == S_RESP && resp_ready) state_d = S_IDLE;
  end
  always_comb begin
    req0_ready = rst_n && state_q == S_IDLE && g0;
    req1_ready = rst_n && state_q == S_IDLE && g1;
    en         = state_q == S_EXEC;
    resp_valid = state_q == S_RESP;
    busy       = state_q != S_IDLE;
    resp_data  = data_q;
    resp_id    = id_q;
  end
  logic_unit #(.WIDTH(WIDTH)) u_lu (
    .en(en),
    .op(op_q),
    .a (a_q),
    .b (b_q),
    .y (lu_y)
  );
endmodule
